eng_imem_unpack: RTL and testbench
==================================

// Module: eng_imem_unpack
// PURPOSE
//   Per-channel buffered unpacker for engine instruction-memory words: each of NUM_CH channels
//   accepts a wide word of SLICES x SLICE_W bits over valid/ready and buffers it in a DEPTH-entry FIFO.
//   It presents the word either as all slices in parallel or as one slice per handshake (serial mode).
//   Sits between the instruction SRAM read port and the engine datapath.
// PARAMETERS
//   NUM_CH   2   independent channels (>=1)
//   SLICES   5   slices per wide word (>=2)
//   SLICE_W  48  bits per slice
//   DEPTH    2   FIFO entries per channel (power of 2, >=2)
//   derived: WORD_W=SLICES*SLICE_W, IDX_W=$clog2(SLICES), CNT_W=$clog2(DEPTH+1)
// PORTS
//   clock        in   1                     single clock, rising edge
//   reset        in   1                     asynchronous, active-low reset
//   mode_serial  in   1                     0=parallel, 1=serial slice output (applied per channel, see below)
//   in_valid     in   NUM_CH                word valid, per channel
//   in_ready     out  NUM_CH                channel can accept a word
//   in_data      in   NUM_CH*WORD_W         channel c at [c*WORD_W +: WORD_W]
//   out_valid    out  NUM_CH                output valid, per channel
//   out_ready    in   NUM_CH                consumer accepts, per channel
//   out_par      out  NUM_CH*WORD_W         parallel mode: head word, same layout as in_data
//   out_slice    out  NUM_CH*SLICE_W        serial mode: current slice
//   out_idx      out  NUM_CH*IDX_W          serial mode: index of current slice
//   out_last     out  NUM_CH                serial mode: current slice is SLICES-1
//   level        out  NUM_CH*CNT_W          FIFO occupancy, per channel
// BEHAVIOUR
//   - Reset asserted (low): every FIFO is flushed, level=0, idx=0, out_valid=0, in_ready=0, and all data
//     outputs are 0. The mode register resets to 0 (parallel). in_ready rises the first edge after release.
//   - Slice k of a word is bits [k*SLICE_W +: SLICE_W]; the slices are contiguous and non-overlapping.
//   - Push when in_valid&in_ready; in_ready=(level<DEPTH). There is no bypass of a full FIFO, so in_ready
//     never depends combinationally on out_ready.
//   - Latency: a word pushed at edge N into an empty FIFO gives out_valid=1 after edge N (visible in cycle N+1).
//   - Push and pop in the same cycle: level is unchanged, and order is strict FIFO with no wrap-around corruption.
//   - Parallel mode: out_valid=(level!=0), and out_par is the head word. A pop occurs on out_valid&out_ready.
//   - Serial mode, per-channel FSM IDLE/SHIFT:
//       IDLE  : level==0; out_valid=0; moves to SHIFT once the FIFO is non-empty.
//       SHIFT : out_valid=1; out_slice=head slice[idx]; out_idx=idx; out_last=(idx==SLICES-1).
//               A handshake with idx<SLICES-1 does idx++.
//               A handshake with idx==SLICES-1 pops the word and sets idx=0; the FSM stays in SHIFT if
//               another word is queued, else returns to IDLE.
//   - Mode register (per channel): loads mode_serial only when level==0 and idx==0. A change while the
//     channel holds data is deferred until the channel drains, so a word is never split across modes.
//   - Output masking: when out_valid=0, out_par/out_slice/out_idx/out_last are 0. In parallel mode
//     out_slice/out_idx/out_last are 0. In serial mode out_par is 0.
//   - Channels are fully independent: a stall on one channel never affects another.
//   - Reset mid-word: an async assert discards the partially shifted word immediately. No output
//     glitches to a non-zero value.
// STRUCTURE
//   - Shared package eng_imem_pkg: slice-index function (idx -> bit offset), the state typedef
//     {ST_IDLE, ST_SHIFT}, and the mode constants MODE_PAR=1'b0 and MODE_SER=1'b1.
//   - One sub-module eng_imem_chan (FIFO + mode register + serial FSM + output masking).
//   - Top level: a generate loop of NUM_CH eng_imem_chan instances plus port packing.
// TESTING
//   - Reset: hold reset low with in_valid=1 -> in_ready=0, out_valid=0, level=0, all data=0.
//     Release reset -> in_ready=1 on the next cycle.
//   - Parallel, ch0: push a word whose slice k=48'h0000_0000_000k (k=0..4), with out_ready=1 ->
//     out_valid 1 cycle later, out_par[47:0]=0, out_par[239:192]=4, and the word is popped in that cycle.
//   - Full/backpressure (DEPTH=2): push words A,B,C back-to-back with out_ready=0 -> level=2, in_ready=0,
//     C held by source. Raise out_ready -> outputs A then B then C, in order.
//   - Serial, ch1: push word W then W2 with out_ready=1 -> out_idx 0,1,2,3,4,0..4; out_last high on idx 4
//     only; 10 consecutive valid cycles with no bubble.
//   - Deferred mode change: toggle mode_serial 0->1 while ch0 holds a word -> that word is emitted in
//     parallel; the next word is emitted serially after the drain.
//   - Independence / mid-word reset: stall ch0 (out_ready=0) while ch1 streams -> ch1 is unaffected.
//     Assert reset at idx=2 -> out_valid=0 immediately and level=0.

Source files
------------

// File: rtl/eng_imem_pkg.sv
// Shared types and helpers for the instruction-memory word unpacker.
package eng_imem_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } shift_st_e;

  localparam logic ModePar = 1'b0;
  localparam logic ModeSer = 1'b1;

  // Bit offset of slice idx inside a packed wide word.
  function automatic int unsigned slice_off(input int unsigned idx, input int unsigned slice_w);
    return idx * slice_w;
  endfunction

endpackage

// File: rtl/eng_imem_chan.sv
// One unpacker channel: word FIFO, deferred mode register, serial slice FSM and output masking.
module eng_imem_chan
  import eng_imem_pkg::*;
#(
  parameter int unsigned Slices = 5,
  parameter int unsigned SliceW = 48,
  parameter int unsigned Depth  = 2,
  localparam int unsigned WordW = Slices * SliceW,
  localparam int unsigned IdxW  = $clog2(Slices),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mode_serial_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WordW-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WordW-1:0]  out_par_o,
  output logic [SliceW-1:0] out_slice_o,
  output logic [IdxW-1:0]   out_idx_o,
  output logic              out_last_o,
  output logic [CntW-1:0]   level_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [WordW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  level_q, level_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             rdy_q;
  shift_st_e        state_q, state_d;

  logic             push, pop, hs, valid, ser, last;
  logic [WordW-1:0] head;

  assign head       = mem_q[rd_ptr_q];
  assign ser        = (mode_q == ModeSer);
  assign last       = (idx_q == IdxW'(Slices - 1));
  // rdy_q keeps in_ready low during reset and for the first cycle after release.
  assign in_ready_o = rdy_q && (level_q < CntW'(Depth));
  assign push       = in_valid_i && in_ready_o;

  always_comb begin
    valid = ser ? (state_q == StShift) : (level_q != '0);
    hs    = valid && out_ready_i;
    pop   = hs && (!ser || last);

    idx_d = idx_q;
    if (hs && ser) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end

    // Mode only follows the input while the channel is fully drained.
    mode_d = ((level_q == '0) && (idx_q == '0)) ? mode_serial_i : mode_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if ((mode_d == ModeSer) && (level_d != '0)) state_d = StShift;
      StShift: if (level_d == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      idx_q    <= '0;
      mode_q   <= ModePar;
      rdy_q    <= 1'b0;
      state_q  <= StIdle;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      rdy_q   <= 1'b1;
      state_q <= state_d;
    end
  end

  // Storage needs no reset: every data output is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_data_i;
  end

  always_comb begin
    out_valid_o = valid;
    out_par_o   = (valid && !ser) ? head : '0;
    out_slice_o = (valid && ser) ? head[slice_off(int'(idx_q), SliceW) +: SliceW] : '0;
    out_idx_o   = (valid && ser) ? idx_q : '0;
    out_last_o  = valid && ser && last;
    level_o     = level_q;
  end

endmodule

// File: rtl/eng_imem_unpack.sv
// Multi-channel instruction-memory word unpacker: independent channels with flat port packing.
module eng_imem_unpack
  import eng_imem_pkg::*;
#(
  parameter int unsigned NumCh  = 2,
  parameter int unsigned Slices = 5,
  parameter int unsigned SliceW = 48,
  parameter int unsigned Depth  = 2,
  localparam int unsigned WordW = Slices * SliceW,
  localparam int unsigned IdxW  = $clog2(Slices),
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    mode_serial_i,
  input  logic [NumCh-1:0]        in_valid_i,
  output logic [NumCh-1:0]        in_ready_o,
  input  logic [NumCh*WordW-1:0]  in_data_i,
  output logic [NumCh-1:0]        out_valid_o,
  input  logic [NumCh-1:0]        out_ready_i,
  output logic [NumCh*WordW-1:0]  out_par_o,
  output logic [NumCh*SliceW-1:0] out_slice_o,
  output logic [NumCh*IdxW-1:0]   out_idx_o,
  output logic [NumCh-1:0]        out_last_o,
  output logic [NumCh*CntW-1:0]   level_o
);

  for (genvar c = 0; c < NumCh; c++) begin : g_chan
    eng_imem_chan #(
      .Slices (Slices),
      .SliceW (SliceW),
      .Depth  (Depth)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .mode_serial_i (mode_serial_i),
      .in_valid_i    (in_valid_i[c]),
      .in_ready_o    (in_ready_o[c]),
      .in_data_i     (in_data_i[c*WordW +: WordW]),
      .out_valid_o   (out_valid_o[c]),
      .out_ready_i   (out_ready_i[c]),
      .out_par_o     (out_par_o[c*WordW +: WordW]),
      .out_slice_o   (out_slice_o[c*SliceW +: SliceW]),
      .out_idx_o     (out_idx_o[c*IdxW +: IdxW]),
      .out_last_o    (out_last_o[c]),
      .level_o       (level_o[c*CntW +: CntW])
    );
  end

endmodule

// File: tb/tb_eng_imem_unpack.sv
// Directed scoreboard bench for eng_imem_unpack (2 channels, 5x48-bit words, depth 2).
module tb_eng_imem_unpack;

  localparam int NCH = 2;
  localparam int SL  = 5;
  localparam int SW  = 48;
  localparam int WW  = SL * SW;
  localparam int IW  = 3;
  localparam int CW  = 2;

  typedef logic [319:0] v_t;
  typedef struct {
    bit ser;
    v_t val;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode_serial;
  logic [NCH-1:0]    in_valid, in_ready, out_valid, out_ready, out_last;
  logic [NCH*WW-1:0] in_data, out_par;
  logic [NCH*SW-1:0] out_slice;
  logic [NCH*IW-1:0] out_idx;
  logic [NCH*CW-1:0] level;

  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   run[NCH];
  int   maxrun[NCH];

  eng_imem_unpack u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .mode_serial_i (mode_serial),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_par_o     (out_par),
    .out_slice_o   (out_slice),
    .out_idx_o     (out_idx),
    .out_last_o    (out_last),
    .level_o       (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input v_t obs, input v_t exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WW-1:0] mk(input logic [SW-1:0] base);
    logic [WW-1:0] w;
    for (int k = 0; k < SL; k++) w[k*SW +: SW] = base + SW'(k);
    return w;
  endfunction

  task automatic sb_push(input int ch, input logic [WW-1:0] w, input bit ser);
    exp_t e;
    if (ser) begin
      for (int k = 0; k < SL; k++) begin
        e.ser = 1'b1;
        e.val = '0;
        e.val[SW-1:0]     = w[k*SW +: SW];
        e.val[SW+IW-1:SW] = IW'(k);
        e.val[SW+IW]      = (k == SL - 1);
        if (ch == 0) q0.push_back(e); else q1.push_back(e);
      end
    end else begin
      e.ser = 1'b0;
      e.val = v_t'(w);
      if (ch == 0) q0.push_back(e); else q1.push_back(e);
    end
  endtask

  task automatic push(input int ch, input logic [WW-1:0] w, input bit ser);
    int n = 0;
    in_valid[ch]          = 1'b1;
    in_data[ch*WW +: WW]  = w;
    while (!in_ready[ch] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_ready", v_t'(in_ready[ch]), v_t'(1'b1));
    if (in_ready[ch]) sb_push(ch, w, ser);
    @(posedge clk); #1;
    in_valid[ch] = 1'b0;
  endtask

  task automatic wait_drain(input int ch, input int lim);
    int n = 0;
    while (((ch == 0) ? q0.size() : q1.size()) != 0 && n < lim) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", v_t'((ch == 0) ? q0.size() : q1.size()), v_t'(0));
  endtask

  // Output monitor: every handshake pops one expected entry; idle outputs must be zero.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      v_t   obs;
      exp_t e;
      obs = '0;
      obs[SW-1:0]     = out_slice[c*SW +: SW];
      obs[SW+IW-1:SW] = out_idx[c*IW +: IW];
      obs[SW+IW]      = out_last[c];
      if (out_valid[c]) begin
        run[c]++;
        if (run[c] > maxrun[c]) maxrun[c] = run[c];
      end else begin
        run[c] = 0;
      end
      if (out_valid[c] && out_ready[c]) begin
        if (((c == 0) ? q0.size() : q1.size()) == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_out: ch%0d observed valid output, expected none", c);
        end else begin
          e = (c == 0) ? q0.pop_front() : q1.pop_front();
          if (e.ser) begin
            chk("ser_slice", obs, e.val);
            chk("ser_par_zero", v_t'(out_par[c*WW +: WW]), v_t'(0));
          end else begin
            chk("par_word", v_t'(out_par[c*WW +: WW]), e.val);
            chk("par_ser_zero", obs, v_t'(0));
          end
        end
      end else if (!out_valid[c]) begin
        chk("idle_zero", obs | v_t'(out_par[c*WW +: WW]), v_t'(0));
      end
    end
  end

  initial begin
    logic [WW-1:0] wa, wb, wc, wx;
    int n;
    rst_n       = 1'b0;
    mode_serial = 1'b0;
    in_valid    = '1;
    in_data     = {8{$urandom()}};
    out_ready   = '0;
    for (int c = 0; c < NCH; c++) begin
      run[c]    = 0;
      maxrun[c] = 0;
    end

    // Reset state with sources asserting valid.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", v_t'(in_ready), v_t'(0));
    chk("rst_out_valid", v_t'(out_valid), v_t'(0));
    chk("rst_level", v_t'(level), v_t'(0));
    chk("rst_data", v_t'({out_par, out_slice, out_idx, out_last}), v_t'(0));
    in_valid = '0;
    #2 rst_n = 1'b1;
    #1 chk("rel_in_ready_low", v_t'(in_ready), v_t'(0));
    @(posedge clk); #1;
    chk("rel_in_ready_high", v_t'(in_ready), v_t'(2'b11));

    // Parallel, ch0: slice k holds k; popped in the first valid cycle.
    out_ready[0] = 1'b1;
    wx = mk(48'h0);
    push(0, wx, 1'b0);
    chk("par_valid", v_t'(out_valid[0]), v_t'(1'b1));
    chk("par_slice0", v_t'(out_par[47:0]), v_t'(0));
    chk("par_slice4", v_t'(out_par[239:192]), v_t'(4));
    chk("par_level1", v_t'(level[CW-1:0]), v_t'(1));
    @(posedge clk); #1;
    chk("par_level0", v_t'(level[CW-1:0]), v_t'(0));
    chk("par_drained", v_t'(q0.size()), v_t'(0));

    // Full / backpressure: A and B fill the FIFO, C is held by the source.
    out_ready[0] = 1'b0;
    wa = mk(48'hA000_0000_0000);
    wb = mk(48'hB000_0000_0000);
    wc = mk(48'hC000_0000_0000);
    push(0, wa, 1'b0);
    push(0, wb, 1'b0);
    in_valid[0]       = 1'b1;
    in_data[WW-1:0]   = wc;
    repeat (2) @(posedge clk);
    #1;
    chk("full_level", v_t'(level[CW-1:0]), v_t'(2));
    chk("full_in_ready", v_t'(in_ready[0]), v_t'(0));
    chk("full_head", v_t'(out_par[WW-1:0]), v_t'(wa));
    out_ready[0] = 1'b1;
    push(0, wc, 1'b0);
    wait_drain(0, 20);

    // Deferred mode change: word queued in parallel mode stays parallel.
    out_ready[0] = 1'b0;
    wa = mk(48'h1111_0000_0000);
    push(0, wa, 1'b0);
    mode_serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("defer_par_out", v_t'(out_par[WW-1:0]), v_t'(wa));
    chk("defer_idx_zero", v_t'(out_idx[IW-1:0]), v_t'(0));
    out_ready[0] = 1'b1;
    wait_drain(0, 20);
    repeat (2) @(posedge clk);
    #1;
    wb = mk(48'h2222_0000_0000);
    push(0, wb, 1'b1);
    wait_drain(0, 20);

    // Serial, ch1: two back-to-back words stream as 10 bubble-free slices.
    out_ready[1] = 1'b1;
    maxrun[1]    = 0;
    wa = mk(48'h3333_0000_0010);
    wb = mk(48'h4444_0000_0020);
    push(1, wa, 1'b1);
    push(1, wb, 1'b1);
    wait_drain(1, 30);
    repeat (2) @(posedge clk);
    #1;
    chk("ser_run10", v_t'(maxrun[1]), v_t'(10));

    // Independence and mid-word reset: ch0 stalled full while ch1 shifts.
    out_ready[0] = 1'b0;
    push(0, mk(48'h5555_0000_0000), 1'b1);
    push(0, mk(48'h6666_0000_0000), 1'b1);
    out_ready[1] = 1'b1;
    push(1, mk(48'h7777_0000_0000), 1'b1);
    n = 0;
    while (!(out_valid[1] && out_idx[IW +: IW] == 3'd2) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("indep_ch1_idx2", v_t'(out_idx[IW +: IW]), v_t'(2));
    chk("indep_ch0_level", v_t'(level[CW-1:0]), v_t'(2));
    chk("indep_ch0_idx", v_t'(out_idx[IW-1:0]), v_t'(0));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", v_t'(out_valid), v_t'(0));
    chk("midrst_level", v_t'(level), v_t'(0));
    chk("midrst_data", v_t'({out_par, out_slice, out_idx, out_last}), v_t'(0));
    q0.delete();
    q1.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_level", v_t'(level), v_t'(0));
    chk("post_rst_ready", v_t'(in_ready), v_t'(2'b11));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
